uart_rx_ctrl: RTL and testbench

- Receive-side controller for the 9-bit UART receiver.
- Gates the receiver's word strobes, buffers accepted words in a small FIFO and presents them to the consumer logic over a valid/ready handshake.
- Counts framing-error events and flags overflow drops, so higher-level command logic never handles raw done/framing_error pulses.

---
 rtl/uart_ctrl_pkg.sv | 14 +
 rtl/uart_word_fifo.sv | 59 +++++
 rtl/uart_rx_ctrl.sv | 98 +++++++++
 tb/tb_uart_rx_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART receive-side controller.
package uart_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      ERR_HOLD = 2'd1,
      RESYNC   = 2'd2
   } rx_ctrl_state_t;

   localparam int UART_WORD_W   = 9;
   localparam int DEFAULT_DEPTH = 8;
   localparam int DEFAULT_ERR_W = 8;

endpackage

// File: rtl/uart_word_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is visible on rd_data
// whenever the FIFO is non-empty.
module uart_word_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);
   assign rd_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: gates receiver strobes through an error/resync FSM,
// buffers accepted words and tracks framing errors and overflow drops.
module uart_rx_ctrl
   import uart_ctrl_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int ERR_W = DEFAULT_ERR_W
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [UART_WORD_W-1:0] rx_data,
   input  logic                   rx_done,
   input  logic                   rx_framing_error,
   input  logic                   enable,
   input  logic                   clear_status,
   output logic [UART_WORD_W-1:0] out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   overflow,
   output logic [ERR_W-1:0]       err_count,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   busy
);

   rx_ctrl_state_t state;
   logic           fe_prev;
   logic           fe_rise;
   logic           fifo_full;
   logic           fifo_empty;
   logic           push_req;
   logic           push;
   logic           pop;
   logic           drop;

   assign fe_rise   = rx_framing_error & ~fe_prev;
   assign out_valid = ~fifo_empty;
   assign pop       = out_valid & out_ready;
   assign push_req  = (state == RUN) & rx_done & enable;
   assign push      = push_req & (~fifo_full | pop);
   assign drop      = push_req & fifo_full & ~pop;
   assign busy      = (state != RUN) | out_valid;

   uart_word_fifo #(
      .WIDTH (UART_WORD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push    (push),
      .wr_data (rx_data),
      .pop     (pop),
      .rd_data (out_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // After an error the first completed word is untrusted, so RESYNC eats one
   // strobe before returning to RUN. A clear in the same cycle as a new event
   // or drop still records that event.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= RUN;
         fe_prev   <= 1'b0;
         overflow  <= 1'b0;
         err_count <= '0;
      end else begin
         fe_prev <= rx_framing_error;

         case (state)
            RUN: begin
               if (fe_rise) state <= ERR_HOLD;
            end
            ERR_HOLD: begin
               if (!rx_framing_error) state <= RESYNC;
            end
            RESYNC: begin
               if (fe_rise)      state <= ERR_HOLD;
               else if (rx_done) state <= RUN;
            end
            default: state <= RUN;
         endcase

         if (clear_status) begin
            overflow <= drop;
         end else if (drop) begin
            overflow <= 1'b1;
         end

         if (clear_status) begin
            err_count <= fe_rise ? ERR_W'(1) : '0;
         end else if (fe_rise && (err_count != '1)) begin
            err_count <= err_count + ERR_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl (DEPTH=8, ERR_W=2).
module tb_uart_rx_ctrl;
   import uart_ctrl_pkg::*;

   localparam int DEPTH = 8;
   localparam int ERR_W = 2;

   logic                   clock = 1'b0;
   logic                   reset;
   logic [UART_WORD_W-1:0] rx_data;
   logic                   rx_done;
   logic                   rx_framing_error;
   logic                   enable;
   logic                   clear_status;
   logic [UART_WORD_W-1:0] out_data;
   logic                   out_valid;
   logic                   out_ready;
   logic                   overflow;
   logic [ERR_W-1:0]       err_count;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                   busy;

   int checks = 0;
   int passed = 0;

   always #5 clock = ~clock;

   uart_rx_ctrl #(
      .DEPTH (DEPTH),
      .ERR_W (ERR_W)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .rx_data          (rx_data),
      .rx_done          (rx_done),
      .rx_framing_error (rx_framing_error),
      .enable           (enable),
      .clear_status     (clear_status),
      .out_data         (out_data),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .overflow         (overflow),
      .err_count        (err_count),
      .fifo_count       (fifo_count),
      .busy             (busy)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end else begin
         passed++;
      end
   endtask

   task automatic applyStimulus(input logic [UART_WORD_W-1:0] word);
      rx_data = word;
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      rx_data = '0;
   endtask

   initial begin
      reset            = 1'b1;
      rx_data          = '0;
      rx_done          = 1'b0;
      rx_framing_error = 1'b0;
      enable           = 1'b0;
      clear_status     = 1'b0;
      out_ready        = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      checkOutput("rst_valid", 32'(out_valid), 0);
      checkOutput("rst_data", 32'(out_data), 0);
      checkOutput("rst_ovf", 32'(overflow), 0);
      checkOutput("rst_err", 32'(err_count), 0);
      checkOutput("rst_count", 32'(fifo_count), 0);
      checkOutput("rst_busy", 32'(busy), 0);

      // Basic push then drain
      enable = 1'b1;
      applyStimulus(9'h0A5);
      applyStimulus(9'h1FF);
      applyStimulus(9'h000);
      checkOutput("basic_count", 32'(fifo_count), 3);
      checkOutput("basic_head", 32'(out_data), 32'h0A5);
      out_ready = 1'b1;
      checkOutput("basic_pop0", 32'(out_data), 32'h0A5);
      tick();
      checkOutput("basic_pop1", 32'(out_data), 32'h1FF);
      tick();
      checkOutput("basic_pop2", 32'(out_data), 32'h000);
      checkOutput("basic_valid2", 32'(out_valid), 1);
      tick();
      checkOutput("basic_empty", 32'(out_valid), 0);
      out_ready = 1'b0;

      // Overflow: nine pushes into eight slots
      for (int i = 1; i <= 9; i++) applyStimulus(UART_WORD_W'(i));
      checkOutput("ovf_count", 32'(fifo_count), 8);
      checkOutput("ovf_flag", 32'(overflow), 1);
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         checkOutput($sformatf("ovf_drain%0d", i), 32'(out_data), 32'(i));
         tick();
      end
      checkOutput("ovf_drained", 32'(out_valid), 0);
      out_ready    = 1'b0;
      clear_status = 1'b1;
      tick();
      clear_status = 1'b0;
      checkOutput("ovf_cleared", 32'(overflow), 0);

      // Full with simultaneous push and pop
      for (int i = 0; i < 8; i++) applyStimulus(UART_WORD_W'(9'h010 + i));
      checkOutput("fullpp_pre", 32'(fifo_count), 8);
      out_ready = 1'b1;
      applyStimulus(9'h155);
      out_ready = 1'b0;
      checkOutput("fullpp_count", 32'(fifo_count), 8);
      checkOutput("fullpp_ovf", 32'(overflow), 0);
      out_ready = 1'b1;
      for (int i = 1; i < 8; i++) begin
         checkOutput($sformatf("fullpp_drain%0d", i), 32'(out_data), 32'h010 + 32'(i));
         tick();
      end
      checkOutput("fullpp_last", 32'(out_data), 32'h155);
      tick();
      checkOutput("fullpp_empty", 32'(out_valid), 0);
      out_ready = 1'b0;

      // Framing error with strobes during the error and one untrusted word after
      rx_framing_error = 1'b1;
      for (int i = 0; i < 50; i++) begin
         rx_data = 9'h1E0;
         rx_done = ((i % 10) == 5);
         tick();
      end
      rx_done = 1'b0;
      checkOutput("fe_err", 32'(err_count), 1);
      checkOutput("fe_busy", 32'(busy), 1);
      checkOutput("fe_nopush", 32'(fifo_count), 0);
      rx_framing_error = 1'b0;
      tick();
      applyStimulus(9'h0AA);
      applyStimulus(9'h0BB);
      checkOutput("fe_count", 32'(fifo_count), 1);
      checkOutput("fe_word", 32'(out_data), 32'h0BB);
      checkOutput("fe_err_after", 32'(err_count), 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput("fe_drained", 32'(busy), 0);

      // Saturation, then clear coinciding with a new error edge
      clear_status = 1'b1;
      tick();
      clear_status = 1'b0;
      checkOutput("sat_clear", 32'(err_count), 0);
      for (int i = 0; i < 5; i++) begin
         rx_framing_error = 1'b1;
         tick();
         rx_framing_error = 1'b0;
         tick();
      end
      checkOutput("sat_value", 32'(err_count), 3);
      rx_framing_error = 1'b1;
      clear_status     = 1'b1;
      tick();
      clear_status     = 1'b0;
      rx_framing_error = 1'b0;
      checkOutput("sat_clear_edge", 32'(err_count), 1);
      tick();
      applyStimulus(9'h000);
      checkOutput("sat_resync_drop", 32'(fifo_count), 0);
      checkOutput("sat_run", 32'(busy), 0);

      // Enable low suppresses pushes without overflow
      enable = 1'b0;
      applyStimulus(9'h0C1);
      applyStimulus(9'h0C2);
      checkOutput("en_count", 32'(fifo_count), 0);
      checkOutput("en_ovf", 32'(overflow), 0);
      enable = 1'b1;

      // Reset mid-stream
      for (int i = 1; i <= 4; i++) applyStimulus(UART_WORD_W'(9'h100 + i));
      checkOutput("rstm_pre", 32'(fifo_count), 4);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("rstm_count", 32'(fifo_count), 0);
      checkOutput("rstm_valid", 32'(out_valid), 0);
      checkOutput("rstm_busy", 32'(busy), 0);

      // Clear coinciding with an overflow drop keeps the new drop
      for (int i = 0; i < 8; i++) applyStimulus(UART_WORD_W'(9'h020 + i));
      clear_status = 1'b1;
      applyStimulus(9'h0FF);
      clear_status = 1'b0;
      checkOutput("clrdrop_ovf", 32'(overflow), 1);
      checkOutput("clrdrop_count", 32'(fifo_count), 8);
      checkOutput("clrdrop_head", 32'(out_data), 32'h020);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
